// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 block: register numbers, exception codes,
// handler entry point and the bit positions of the stored SR/Cause fields.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int IP_HI   = 15;
    localparam int IP_LO   = 10;
    localparam int EXC_HI  = 6;
    localparam int EXC_LO  = 2;

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_target(input logic [31:0] vpc, input logic bd);
        logic [31:0] aligned;
        aligned = vpc & ~32'h3;
        return bd ? aligned - 32'd4 : aligned;
    endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// Pipeline-to-CP0 signal bundle; the M stage is master, cp0_unit is slave.
interface cp0_unit_if;
    logic        en;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    modport master (
        output en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  CP0Out, EPCOut, Req
    );

    modport slave (
        input  en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output CP0Out, EPCOut, Req
    );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC, interrupt/exception request and mfc0/mtc0/eret paths.
// Optional PRId register (reg 15) is built only when CP0_PRID_EN is defined.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h2023_0001
) (
    input  logic       clk,
    input  logic       reset,
    cp0_unit_if.slave  bus
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic        w_wr_sr;
    logic        w_wr_epc;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic [31:0] w_rdata;

    assign w_int_req = (|(bus.HWInt & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (bus.ExcCodeIn != 5'd0) & ~r_exl;
    assign w_req     = (w_int_req | w_exc_req) & ~reset;
    assign w_wr_sr   = bus.en && (bus.CP0Add == REG_SR);
    assign w_wr_epc  = bus.en && (bus.CP0Add == REG_EPC);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im      <= '0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= '0;
            r_exccode <= '0;
            r_epc     <= '0;
        end else begin
            r_ip <= bus.HWInt;
            if (w_req) begin
                // Taking the trap swallows any mtc0 or eret in the same slot.
                r_exl     <= 1'b1;
                r_exccode <= w_int_req ? EXC_INT : bus.ExcCodeIn;
                r_bd      <= bus.BDIn;
                r_epc     <= epc_target(bus.VPC, bus.BDIn);
            end else begin
                if (w_wr_sr) begin
                    r_im  <= bus.CP0In[IM_HI:IM_LO];
                    r_exl <= bus.CP0In[EXL_BIT];
                    r_ie  <= bus.CP0In[IE_BIT];
                end
                if (w_wr_epc) begin
                    r_epc <= bus.CP0In;
                end
                if (bus.EXLClr) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_sr                 = '0;
        w_sr[IM_HI:IM_LO]    = r_im;
        w_sr[EXL_BIT]        = r_exl;
        w_sr[IE_BIT]         = r_ie;
        w_cause              = '0;
        w_cause[BD_BIT]      = r_bd;
        w_cause[IP_HI:IP_LO] = r_ip;
        w_cause[EXC_HI:EXC_LO] = r_exccode;
    end

    always_comb begin
        w_rdata = '0;
        case (bus.CP0Add)
            REG_SR:    w_rdata = w_sr;
            REG_CAUSE: w_rdata = w_cause;
            REG_EPC:   w_rdata = r_epc;
`ifdef CP0_PRID_EN
            REG_PRID:  w_rdata = PRID_VAL;
`endif
            default:   w_rdata = '0;
        endcase
    end

`ifndef CP0_PRID_EN
    logic w_unused_prid;
    assign w_unused_prid = ^PRID_VAL;
`endif

    assign bus.CP0Out = w_rdata;
    // An mtc0 EPC paired with a following eret must redirect to the new value.
    assign bus.EPCOut = w_wr_epc ? bus.CP0In : r_epc;
    assign bus.Req    = w_req;

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 block for the five-stage pipeline: holds SR, Cause and EPC and evaluates interrupt and exception conditions for the instruction in M. It drives the single `Req` flush line that every pipeline register consumes to flush and load the handler PC. It also serves `mfc0`/`mtc0` traffic and supplies EPC for `eret`. Instantiated in the M stage, next to DM.

## Interface
Parameters:
- `PRID_VAL`, `32'h2023_0001`: read-only value of PRId; used only when PRId is compiled in.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `en`  in  1  `mtc0` write enable from M.
- `CP0Add`  in  5  register number for read/write.
- `CP0In`  in  32  `mtc0` write data.
- `CP0Out`  out  32  `mfc0` read data, combinational.
- `VPC`  in  32  PC of the instruction in M.
- `BDIn`  in  1  instruction in M is in a branch delay slot.
- `ExcCodeIn`  in  5  exception code from M; 0 means none.
- `HWInt`  in  6  external interrupt lines (timer0, timer1, interrupt generator, 3 spare).
- `EXLClr`  in  1  `eret` in M.
- `EPCOut`  out  32  EPC value for `eret` redirect.
- `Req`  out  1  flush request to F/D/E/M/W registers, combinational.

## Operation
State and stored fields:
- SR (12) stores only IM[15:10], EXL[1] and IE[0]; all other bits read 0.
- Cause (13) stores BD[31], IP[15:10] and ExcCode[6:2]; all other bits read 0. Cause is read-only to `mtc0`; writes to it are ignored.
- EPC (14) is a full 32-bit register.
- Addresses other than 12/13/14 (and 15 when PRId is enabled) read 0, and writes to them are ignored.

Request logic:
- IntReq = `|(HWInt & SR.IM)` & IE & ~EXL.
- ExcReq = (ExcCodeIn != 0) & ~EXL.
- `Req` = (IntReq | ExcReq) & ~reset.
- An interrupt has priority over an exception in the same cycle.

Updates on posedge when `Req` is high:
- EXL <= 1.
- ExcCode <= IntReq ? 0 : ExcCodeIn.
- BD <= BDIn.
- EPC <= BDIn ? {VPC[31:2],2'b00} - 4 : {VPC[31:2],2'b00}.
- Any concurrent `mtc0` write or `EXLClr` is discarded.

Other posedge updates:
- If `Req` is low and `EXLClr` is high: EXL <= 0.
- If `Req` is low, `en` is high and `CP0Add` is 12 or 14: write SR (masked to the stored fields) or EPC. If `EXLClr` is also high, EXL <= 0 takes priority over the written EXL bit.
- IP <= `HWInt` every cycle, including while EXL is set; only reset overrides it.

Read paths:
- `EPCOut` = (`en` && `CP0Add`==14) ? `CP0In` : EPC. This forwards an `mtc0 EPC` that sits in M together with a following `eret`.

## Timing
- Reset value of every register field is 0. During reset, `Req` = 0, `CP0Out` reads the cleared fields, and `EPCOut` follows the bypass rule with EPC = 0.
- `Req` is combinational in the same cycle as the faulting instruction in M. On the following posedge, pipeline registers load the handler entry `32'h0000_4180`.
- SR/Cause/EPC reflect the exception in the cycle after `Req`.
- IP lags `HWInt` by one cycle.
- `Req` stays low while EXL = 1, so handlers do not nest.
- If `reset` and a request coincide, reset wins.

## Configuration
- Macro `CP0_PRID_EN`.
- Defined: register 15 reads `PRID_VAL`, and writes to it are ignored.
- Undefined: register 15 reads 0; no PRId logic is synthesized.

## Structure
- Shared package `cp0_pkg` holds:
  - register numbers: SR=12, CAUSE=13, EPC=14, PRID=15;
  - ExcCode constants: INT=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12;
  - `EXC_ENTRY` = `32'h0000_4180`;
  - bit-position constants for IM, EXL, IE, BD, IP and ExcCode.
- No sub-module: the block is a single module. The request logic is too small to split out.

## Test plan
- Reset held 2 cycles with `HWInt`=6'h3f: `Req`=0, and reads of SR, Cause and EPC all return 0.
- `mtc0` SR=`32'h0000_0401` (IM0, IE), then `HWInt`=6'h01 with VPC=`32'h3010`: `Req`=1 in that cycle. Next cycle: EPC=`32'h3010`, ExcCode=0, EXL=1, and `Req`=0 although `HWInt` is still asserted.
- `ExcCodeIn`=12 with BDIn=1 and VPC=`32'h3024`: EPC=`32'h3020`, Cause reads `32'h8000_0030`.
- Same cycle: `HWInt`=6'h01 enabled and `ExcCodeIn`=4: ExcCode recorded as 0, and the concurrent `mtc0` EPC=`32'h5000` is discarded.
- Handler flow: EXL=1, then `mtc0` EPC=`32'h3100` with `en` and `EXLClr` in the same cycle. `EPCOut`=`32'h3100` combinationally; next cycle EXL=0.
- Read CP0Add=15: returns `PRID_VAL` when built with `CP0_PRID_EN`, 0 when built without it.
